// File: rtl/counter_prog.sv
// Purpose : host-side sequencer that programs (control word + value) and reads back the
//           three-channel counter block, and turns its expiry lines into sticky interrupts.
// Latency : accept to rsp_valid = 2*WE_HOLD+2 (load), READ_LAT+2 (read), 1 (illegal channel).
// Backpr. : one request in flight; req_ready is high only in IDLE, and req_valid seen while
//           busy is dropped rather than queued.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_ready        host request handshake
//   req_op/ch/mode/val         request fields (op 0 = load, 1 = read; ch 3 is illegal)
//   rsp_valid/err/data         one-cycle completion pulse, error flag, read data
//   irq_clr, irq               per-channel clear, sticky expiry flags
//   counter_we/ch/val/out      write strobe, select, write data, readback of the counter block
//   counter0/1/2_OUT           asynchronous channel expiry lines

module counter_prog #(
   parameter int unsigned READ_LAT = 2,   // cycles from select to sample, 1..7
   parameter int unsigned WE_HOLD  = 1    // strobe width per write, 1..3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_op,
   input  logic [1:0]  req_ch,
   input  logic [2:0]  req_mode,
   input  logic [31:0] req_val,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   input  logic [2:0]  irq_clr,
   output logic [2:0]  irq,
   output logic        counter_we,
   output logic [1:0]  counter_ch,
   output logic [31:0] counter_val,
   input  logic [31:0] counter_out,
   input  logic        counter0_OUT,
   input  logic        counter1_OUT,
   input  logic        counter2_OUT
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CTRL = 3'd1;
   localparam logic [2:0] S_LOAD = 3'd2;
   localparam logic [2:0] S_SEL  = 3'd3;
   localparam logic [2:0] S_CAP  = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   localparam logic [2:0] WE_CNT  = 3'(WE_HOLD);
   localparam logic [2:0] WE_LAST = 3'(WE_HOLD - 1);
   localparam logic [2:0] RL_LAST = 3'(READ_LAT - 1);

   // Channel select value that addresses the control-word register.
   localparam logic [1:0] CTRL_SEL = 2'd3;

   logic [2:0]  state;
   logic [2:0]  cnt;
   logic        op_q;
   logic [1:0]  ch_q;
   logic [2:0]  mode_q;
   logic [31:0] val_q;
   logic        err_q;

   assign req_ready = (state == S_IDLE);

   // ------------------------------------------------------------------
   // Request sequencer. Every interface output is registered from the
   // current state, so it shows up one cycle after the state that
   // produces it. That lag is what places counter_ch exactly READ_LAT
   // cycles ahead of the CAP sampling edge, and puts rsp_valid one
   // cycle after RESP (when the FSM is already back in IDLE).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_q        <= 1'b0;
         ch_q        <= '0;
         mode_q      <= '0;
         val_q       <= '0;
         err_q       <= 1'b0;
         counter_we  <= 1'b0;
         counter_ch  <= '0;
         counter_val <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
      end else begin
         // Strobe, write data and response flags are pulses; counter_ch
         // and rsp_data deliberately hold.
         counter_we  <= 1'b0;
         counter_val <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  ch_q   <= req_ch;
                  mode_q <= req_mode;
                  val_q  <= req_val;
                  cnt    <= '0;
                  if (req_ch == 2'd3) begin
                     err_q <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= req_op ? S_SEL : S_CTRL;
                  end
               end
            end

            // WE_HOLD strobe cycles, then one extra cycle with the strobe
            // low so the control write and value write never touch.
            S_CTRL: begin
               counter_ch <= CTRL_SEL;
               if (cnt < WE_CNT) begin
                  counter_we  <= 1'b1;
                  counter_val <= {6'b0, ch_q, 21'b0, mode_q};
               end
               if (cnt == WE_CNT) begin
                  cnt   <= '0;
                  state <= S_LOAD;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

            S_LOAD: begin
               counter_ch  <= ch_q;
               counter_we  <= 1'b1;
               counter_val <= val_q;
               if (cnt == WE_LAST) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

            S_SEL: begin
               counter_ch <= ch_q;
               if (cnt == RL_LAST) begin
                  state <= S_CAP;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end

            S_CAP: begin
               rsp_data <= counter_out;
               state    <= S_RESP;
            end

            S_RESP: begin
               rsp_valid <= 1'b1;
               rsp_err   <= err_q;
               // Only a successful read leaves captured data visible.
               if (err_q || !op_q) begin
                  rsp_data <= '0;
               end
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Expiry interrupts: two-flop synchroniser, rising-edge detect, sticky
   // flag. A new edge in the same cycle as a clear keeps the flag set so
   // an expiry is never lost. Independent of the request FSM.
   // ------------------------------------------------------------------
   logic [2:0] exp_raw;
   logic [2:0] exp_meta;
   logic [2:0] exp_sync;
   logic [2:0] exp_prev;
   logic [2:0] exp_rise;

   assign exp_raw  = {counter2_OUT, counter1_OUT, counter0_OUT};
   assign exp_rise = exp_sync & ~exp_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_meta <= '0;
         exp_sync <= '0;
         exp_prev <= '0;
         irq      <= '0;
      end else begin
         exp_meta <= exp_raw;
         exp_sync <= exp_meta;
         exp_prev <= exp_sync;
         irq      <= (irq & ~irq_clr) | exp_rise;
      end
   end

endmodule

// File: tb/tb_counter_prog.sv
// Purpose : directed self-checking bench for counter_prog with a response scoreboard.
// Latency : checks exact accept-to-response latency at default parameters.
// Backpr. : exercises held req_valid across back-to-back requests.

module tb_counter_prog;

   localparam int unsigned READ_LAT = 2;
   localparam int unsigned WE_HOLD  = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [1:0]  req_ch;
   logic [2:0]  req_mode;
   logic [31:0] req_val;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_data;
   logic [2:0]  irq_clr;
   logic [2:0]  irq;
   logic        counter_we;
   logic [1:0]  counter_ch;
   logic [31:0] counter_val;
   logic [31:0] counter_out;
   logic        counter0_OUT;
   logic        counter1_OUT;
   logic        counter2_OUT;

   always #5 clk = ~clk;

   counter_prog #(
      .READ_LAT (READ_LAT),
      .WE_HOLD  (WE_HOLD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_ch       (req_ch),
      .req_mode     (req_mode),
      .req_val      (req_val),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_data     (rsp_data),
      .irq_clr      (irq_clr),
      .irq          (irq),
      .counter_we   (counter_we),
      .counter_ch   (counter_ch),
      .counter_val  (counter_val),
      .counter_out  (counter_out),
      .counter0_OUT (counter0_OUT),
      .counter1_OUT (counter1_OUT),
      .counter2_OUT (counter2_OUT)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_q[$];

   int n_cmp   = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int acc_cyc = 0;
   int we_cnt  = 0;
   int rsp_cnt = 0;

   function automatic rsp_t mk(input logic err, input logic [31:0] data);
      rsp_t r;
      r.err  = err;
      r.data = data;
      return r;
   endfunction

   // Advance one clock; outputs are observed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (counter_we) we_cnt++;
      if (rsp_valid)  rsp_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request and wait (bounded) for the accepting edge.
   task automatic issue(input string tag, input logic op, input logic [1:0] ch,
                        input logic [2:0] mode, input logic [31:0] val, input bit keep);
      logic got;
      got       = 1'b0;
      req_op    = op;
      req_ch    = ch;
      req_mode  = mode;
      req_val   = val;
      req_valid = 1'b1;
      we_cnt    = 0;
      rsp_cnt   = 0;
      for (int i = 0; i < 30 && !got; i++) begin
         got = req_ready;
         tick();
      end
      acc_cyc = cyc;
      if (!keep) req_valid = 1'b0;
      chk({tag, " accept"}, 32'(got), 32'd1);
   endtask

   // Wait (bounded) for rsp_valid, then check latency, busy-ready, and the
   // scoreboard entry; finally check the pulse lasts exactly one cycle.
   task automatic wait_rsp(input string tag, input int exp_lat);
      int   leak;
      int   n;
      rsp_t e;
      leak = 0;
      n    = 0;
      while (!rsp_valid && n < 20) begin
         if (req_ready) leak++;
         tick();
         n++;
      end
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
      chk({tag, " ready low while busy"}, 32'(leak), 32'd0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '1;
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, " rsp_data"}, rsp_data, e.data);
      tick();
      chk({tag, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_op       = 1'b0;
      req_ch       = 2'd0;
      req_mode     = 3'd0;
      req_val      = 32'd0;
      irq_clr      = 3'd0;
      counter_out  = 32'd0;
      counter0_OUT = 1'b0;
      counter1_OUT = 1'b0;
      counter2_OUT = 1'b0;

      // ---- reset state
      #12;
      chk("reset req_ready",   32'(req_ready),  32'd1);
      chk("reset counter_we",  32'(counter_we), 32'd0);
      chk("reset counter_ch",  32'(counter_ch), 32'd0);
      chk("reset counter_val", counter_val,     32'd0);
      chk("reset rsp_valid",   32'(rsp_valid),  32'd0);
      chk("reset rsp_err",     32'(rsp_err),    32'd0);
      chk("reset rsp_data",    rsp_data,        32'd0);
      chk("reset irq",         32'(irq),        32'd0);
      tick();
      rst = 1'b1;
      tick();

      // ---- load ch1 mode2 val 0x10, with a channel-0 expiry edge mid-load
      exp_q.push_back(mk(1'b0, 32'd0));
      issue("load", 1'b0, 2'd1, 3'd2, 32'h10, 1'b0);
      counter0_OUT = 1'b1;
      chk("load ready drops", 32'(req_ready), 32'd0);
      tick();
      chk("load ctrl we",  32'(counter_we), 32'd1);
      chk("load ctrl ch",  32'(counter_ch), 32'd3);
      chk("load ctrl val", counter_val,     32'h0100_0002);
      tick();
      chk("load gap we",        32'(counter_we), 32'd0);
      chk("irq not yet synced", 32'(irq),        32'd0);
      tick();
      chk("load value we",  32'(counter_we), 32'd1);
      chk("load value ch",  32'(counter_ch), 32'd1);
      chk("load value val", counter_val,     32'h10);
      chk("irq0 set",       32'(irq),        32'd1);
      tick();
      chk("load we idle",  32'(counter_we), 32'd0);
      chk("load val idle", counter_val,     32'd0);
      wait_rsp("load", 4);
      chk("load strobe count", 32'(we_cnt),     32'd2);
      chk("load ch holds",     32'(counter_ch), 32'd1);

      // ---- read ch2
      counter_out = 32'hDEAD_BEEF;
      exp_q.push_back(mk(1'b0, 32'hDEAD_BEEF));
      issue("read", 1'b1, 2'd2, 3'd0, 32'd0, 1'b0);
      tick();
      chk("read select ch", 32'(counter_ch), 32'd2);
      wait_rsp("read", 4);
      chk("read no strobe", 32'(we_cnt), 32'd0);

      // ---- illegal channel
      exp_q.push_back(mk(1'b1, 32'd0));
      issue("err", 1'b0, 2'd3, 3'd5, 32'hFFFF, 1'b0);
      wait_rsp("err", 1);
      chk("err no strobe", 32'(we_cnt), 32'd0);

      // ---- interrupt clear, then edge and clear in the same cycle
      irq_clr = 3'b001;
      tick();
      irq_clr = 3'b000;
      chk("irq0 cleared", 32'(irq), 32'd0);
      counter0_OUT = 1'b0;
      tick();
      tick();
      tick();
      counter0_OUT = 1'b1;
      counter2_OUT = 1'b1;
      tick();
      tick();
      irq_clr = 3'b001;
      tick();
      irq_clr = 3'b000;
      chk("irq set beats clear", 32'(irq), 32'h5);
      irq_clr = 3'b100;
      tick();
      irq_clr = 3'b000;
      chk("irq2 cleared only", 32'(irq), 32'h1);

      // ---- asynchronous reset during the value write
      issue("abort", 1'b0, 2'd0, 3'd1, 32'h55, 1'b0);
      tick();
      tick();
      tick();
      chk("abort strobe before reset", 32'(counter_we), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort we cleared",  32'(counter_we), 32'd0);
      chk("abort ready",       32'(req_ready),  32'd1);
      chk("abort val cleared", counter_val,     32'd0);
      chk("abort irq cleared", 32'(irq),        32'd0);
      tick();
      rst     = 1'b1;
      rsp_cnt = 0;
      we_cnt  = 0;
      repeat (6) tick();
      chk("abort no response", 32'(rsp_cnt), 32'd0);
      chk("abort no late write", 32'(we_cnt), 32'd0);

      // ---- read after reset
      counter_out = 32'h1234_5678;
      exp_q.push_back(mk(1'b0, 32'h1234_5678));
      issue("read after reset", 1'b1, 2'd0, 3'd0, 32'd0, 1'b0);
      wait_rsp("read after reset", 4);

      // ---- back-to-back reads with req_valid held high
      counter_out = 32'hA5A5_0001;
      exp_q.push_back(mk(1'b0, 32'hA5A5_0001));
      exp_q.push_back(mk(1'b0, 32'h5A5A_0002));
      issue("b2b first", 1'b1, 2'd1, 3'd0, 32'd0, 1'b1);
      wait_rsp("b2b first", 4);
      // The second request is accepted on the edge that ends the first
      // response cycle, so this cycle is its accept reference.
      req_valid   = 1'b0;
      counter_out = 32'h5A5A_0002;
      acc_cyc     = cyc;
      wait_rsp("b2b second", 4);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
